id_ex_stage: RTL

ID/EX pipeline register of the five-stage RISC-V core, with integrated load-use hazard detection. It captures decoded operands, immediate, register addresses and control (including ALUOp and the 4-bit Funct field {funct7[5], funct3}) at the end of ID. It presents them to EX, where ALU control, the ALU and the forwarding muxes consume them. It inserts bubbles on branch flush and load-use hazards, and holds its contents under a global pipeline hold.

---
 rtl/core_pkg.sv | 37 +++
 rtl/load_use_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width defaults, ALUOp encodings,
// Funct field layout and the packed EX control bundle with its bubble value.
package core_pkg;

  localparam int unsigned XLEN_DFLT = 64;
  localparam int unsigned RAW_DFLT  = 5;
  localparam int unsigned ALUOP_W   = 2;
  localparam int unsigned FUNCT_W   = 4;

  // ALU operation class handed to ALU control in EX
  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_LDST   = 2'b00,  // address add for loads/stores
    ALUOP_BRANCH = 2'b01,  // subtract for branch compare
    ALUOP_RTYPE  = 2'b10   // decode from Funct
  } aluop_e;

  // Funct field: {funct7[5], funct3}
  typedef struct packed {
    logic       f7b5;
    logic [2:0] f3;
  } funct_t;

  // Control bits carried from ID into EX
  typedef struct packed {
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // A bubble: no writeback, no memory access, ALUOp 00
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector. Raises stall when the instruction in
// EX is a load whose non-zero destination is read by the valid ID instruction.
// Only compiled when ID_EX_HAZARD_EN is defined.
// Ports: ex_valid, ex_mem_read, ex_rd (EX state); id_valid, id_rs1, id_rs2
// (ID inputs); stall (combinational out).
`ifdef ID_EX_HAZARD_EN
module load_use_detect #(
  parameter int unsigned RAW = 5
) (
  input  logic           ex_valid,
  input  logic           ex_mem_read,
  input  logic [RAW-1:0] ex_rd,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  output logic           stall
);

  // x0 is never a hazard source
  assign stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion.
// Captures ID operands, immediate, register addresses and control at the end of
// ID and presents them to EX. Priority per edge: flush bubble, hold, load-use
// bubble, load.
// Optional feature macro: ID_EX_HAZARD_EN (load-use detection; when undefined
// stall_if is tied low).
// Ports: clk, reset_n (async active-low); id_* (ID slot inputs); flush, hold;
// ex_* (registered EX slot); stall_if (combinational load-use stall).
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DFLT,
  parameter int unsigned RAW  = RAW_DFLT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RAW-1:0]     id_rs1,
  input  logic [RAW-1:0]     id_rs2,
  input  logic [RAW-1:0]     id_rd,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic [FUNCT_W-1:0] id_Funct,
  input  logic               id_ALUSrc,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_RegWrite,
  input  logic               id_MemtoReg,
  input  logic               id_Branch,
  input  logic               flush,
  input  logic               hold,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RAW-1:0]     ex_rs1,
  output logic [RAW-1:0]     ex_rs2,
  output logic [RAW-1:0]     ex_rd,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [FUNCT_W-1:0] ex_Funct,
  output logic               ex_ALUSrc,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_RegWrite,
  output logic               ex_MemtoReg,
  output logic               ex_Branch,
  output logic               stall_if
);

  ctrl_t id_ctrl;
  ctrl_t id_ctrl_gated;
  ctrl_t ex_ctrl;

  // Bundle ID control; an invalid ID slot contributes no side effects
  always_comb begin
    id_ctrl            = BUBBLE;
    id_ctrl.alu_src    = id_ALUSrc;
    id_ctrl.mem_read   = id_MemRead;
    id_ctrl.mem_write  = id_MemWrite;
    id_ctrl.reg_write  = id_RegWrite;
    id_ctrl.mem_to_reg = id_MemtoReg;
    id_ctrl.branch     = id_Branch;
    id_ctrl.alu_op     = id_ALUOp;
    id_ctrl_gated      = id_valid ? id_ctrl : BUBBLE;
  end

  // Load-use stall, combinational from EX state and ID inputs
`ifdef ID_EX_HAZARD_EN
  load_use_detect #(
    .RAW (RAW)
  ) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .stall       (stall_if)
  );
`else
  assign stall_if = 1'b0;
`endif

  // EX slot register: flush > hold > stall bubble > load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_Funct    <= '0;
      ex_ctrl     <= BUBBLE;
    end else if (flush || (!hold && stall_if)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_Funct    <= '0;
      ex_ctrl     <= BUBBLE;
    end else if (!hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_Funct    <= id_Funct;
      ex_ctrl     <= id_ctrl_gated;
    end
  end

  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_MemRead  = ex_ctrl.mem_read;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemtoReg = ex_ctrl.mem_to_reg;
  assign ex_Branch   = ex_ctrl.branch;
  assign ex_ALUOp    = ex_ctrl.alu_op;

endmodule
